// File: rtl/mmio_ps2_rx.sv
// Memory-mapped PS/2 device-to-host receiver with a byte FIFO, DATA/STATUS registers and IRQ.
// Define MMIO_PS2_PARITY_EN to enable odd-parity checking and the PERR status flag.
module mmio_ps2_rx #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_ps2_clk,
  input  logic        i_ps2_data,
  input  logic        i_rdEn,
  input  logic [1:0]  i_rdAddr,
  output logic [31:0] o_rdData,
  output logic        o_irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          ps2_data;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [TW-1:0] to_cnt;
  logic          done;
  logic          stop_ok;
  logic          par_ok;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          ferr;
  logic          perr;
  logic          push_ev;
  logic          pop;
  logic          wr;
  logic          ovf_ev;
  logic          stat_rd;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], i_ps2_clk};
      data_sync <= {data_sync[0], i_ps2_data};
    end
  end

  assign ps2_data = data_sync[1];

  // A level change is accepted on the FILTER_LEN-th consecutive differing sample.
  assign fall = clk_filt && !clk_sync[1] && (filt_cnt == FW'(FILTER_LEN - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync[1] == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      clk_filt <= clk_sync[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

`ifdef MMIO_PS2_PARITY_EN
  logic par_bit;
  logic par_good;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      par_bit  <= 1'b0;
      par_good <= 1'b1;
    end else if (fall && state == S_PARITY) begin
      par_bit <= ps2_data;
    end else if (fall && state == S_STOP) begin
      par_good <= ^{shift, par_bit};
    end
  end

  assign par_ok = par_good;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) perr <= 1'b0;
    else            perr <= (done && !par_ok) || (perr && !stat_rd);
  end
`else
  assign par_ok = 1'b1;
  assign perr   = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      to_cnt  <= '0;
      done    <= 1'b0;
      stop_ok <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (state)
          S_IDLE: begin
            if (!ps2_data) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shift   <= {ps2_data, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: state <= S_STOP;
          default: begin
            done    <= 1'b1;
            stop_ok <= ps2_data;
            state   <= S_IDLE;
          end
        endcase
      end else if (state != S_IDLE) begin
        if (to_cnt == TW'(TIMEOUT_CYC)) begin
          state  <= S_IDLE;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end
    end
  end

  // shift is stable during the push cycle: the next frame cannot shift for several cycles.
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push_ev = done && stop_ok && par_ok;
  assign pop     = i_rdEn && (i_rdAddr == 2'd0) && !empty;
  assign stat_rd = i_rdEn && (i_rdAddr == 2'd1);
  assign wr      = push_ev && (!full || pop);
  assign ovf_ev  = push_ev && full && !pop;

  always_ff @(posedge i_clk) begin
    if (wr) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      ferr   <= 1'b0;
      o_irq  <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      ovf   <= ovf_ev || (ovf && !stat_rd);
      ferr  <= (done && !stop_ok) || (ferr && !stat_rd);
      o_irq <= !empty;
    end
  end

  always_comb begin
    o_rdData = '0;
    case (i_rdAddr)
      2'd0: if (!empty) o_rdData = {23'b0, 1'b1, mem[rd_ptr]};
      2'd1: o_rdData = {16'b0, 8'(count), 3'b0, perr, ferr, ovf, full, !empty};
      default: o_rdData = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_ps2_rx.sv
// Randomised and directed bench for mmio_ps2_rx, checked against a queue-based model.
`timescale 1ns/1ps
module tb_mmio_ps2_rx;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned HALF    = 20;
`ifdef MMIO_PS2_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2c = 1'b1;
  logic        ps2d = 1'b1;
  logic        rd_en = 1'b0;
  logic [1:0]  rd_addr = 2'd0;
  logic [31:0] rd_data;
  logic        irq;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  logic [7:0] mq[$];
  bit m_ovf, m_ferr, m_perr;

  mmio_ps2_rx #(.DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYC(TIMEOUT)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_ps2_clk(ps2c), .i_ps2_data(ps2d),
    .i_rdEn(rd_en), .i_rdAddr(rd_addr), .o_rdData(rd_data), .o_irq(irq)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic model_read(input logic [1:0] a, output logic [31:0] e);
    e = '0;
    if (a == 2'd0) begin
      if (mq.size() != 0) begin
        e = {23'b0, 1'b1, mq[0]};
        void'(mq.pop_front());
      end
    end else if (a == 2'd1) begin
      e[0] = (mq.size() != 0);
      e[1] = (mq.size() == DEPTH);
      e[2] = m_ovf;
      e[3] = m_ferr;
      e[4] = m_perr;
      e[15:8] = 8'(mq.size());
      m_ovf = 0; m_ferr = 0; m_perr = 0;
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit par_bad, input bit stop_ok);
    bit bad_par;
    bad_par = PAR_EN && par_bad;
    if (!stop_ok) m_ferr = 1;
    if (bad_par)  m_perr = 1;
    if (stop_ok && !bad_par) begin
      if (mq.size() < DEPTH) mq.push_back(b);
      else m_ovf = 1;
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = a;
    #1 d = rd_data;
    @(negedge clk);
    rd_en = 1'b0; rd_addr = 2'd0;
  endtask

  // Pins change on negedge; with align the DATA read lands on the push edge of this fall.
  task automatic ps2_bit(input bit b, input bit glitch, input bit align, output logic [31:0] d);
    d = '0;
    @(negedge clk);
    ps2d = b;
    if (glitch) begin
      repeat (8) @(negedge clk);
      ps2c = 1'b0;
      repeat (2) @(negedge clk);
      ps2c = 1'b1;
      repeat (HALF - 10) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2c = 1'b0;
    if (align) begin
      repeat (6) @(negedge clk);
      rd_en = 1'b1; rd_addr = 2'd0;
      #1 d = rd_data;
      @(negedge clk);
      rd_en = 1'b0;
      repeat (HALF - 7) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop,
                            input bit glitch, input bit align, output logic [31:0] d);
    logic p;
    logic [31:0] dd;
    bit v;
    p = ~(^b) ^ par_flip;
    d = '0;
    for (int i = 0; i < 11; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i < 9)  v = b[i-1];
      else if (i == 9) v = p;
      else             v = stop;
      ps2_bit(v, glitch && i == 4, align && i == 10, dd);
      if (i == 10) d = dd;
    end
    ps2d = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    rd_addr = 2'd0; #1;
    n_cmp++;
    if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", rd_data); end
    rd_addr = 2'd1; #1;
    n_cmp++;
    if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", rd_data); end
    rd_addr = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_good_frame;
    logic [31:0] d;
    send_frame(8'h1C, 0, 1, 0, 0, d);
    n_cmp++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL good_irq_rise: got %b want 1", irq); end
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h0000_011C) begin n_fail++; $display("FAIL good_data: got %h want 0000011c", d); end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL good_irq_fall: got %b want 0", irq); end
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL good_empty: got %h want 0", d); end
  endtask

  task automatic test_parity;
    logic [31:0] d;
    send_frame(8'h1C, 1, 1, 0, 0, d);
    if (PAR_EN) begin
      bus_read(2'd1, d);
      n_cmp++;
      if (d !== 32'h0000_0010) begin n_fail++; $display("FAIL parity_status: got %h want 00000010", d); end
    end else begin
      bus_read(2'd0, d);
      n_cmp++;
      if (d !== 32'h0000_011C) begin n_fail++; $display("FAIL parity_ignored: got %h want 0000011c", d); end
    end
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL parity_clear: got %h want 0", d); end
  endtask

  task automatic test_stop_err;
    logic [31:0] d;
    send_frame(8'h5A, 0, 0, 0, 0, d);
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 32'h0000_0008) begin n_fail++; $display("FAIL ferr_status: got %h want 00000008", d); end
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ferr_clear: got %h want 0", d); end
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ferr_data: got %h want 0", d); end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1, 0, 0, d);
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 32'h0000_0807) begin n_fail++; $display("FAIL ovf_status: got %h want 00000807", d); end
    for (int i = 1; i <= 8; i++) begin
      bus_read(2'd0, d);
      n_cmp++;
      if (d !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL ovf_data%0d: got %h want %h", i, d, 32'h100 + 32'(i)); end
    end
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ovf_lost: got %h want 0", d); end
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL ovf_clear: got %h want 0", d); end
  endtask

  task automatic test_timeout;
    logic [31:0] d;
    logic [7:0] junk;
    junk = 8'(32'($urandom));
    ps2_bit(1'b0, 0, 0, d);
    for (int i = 0; i < 4; i++) ps2_bit(junk[i], 0, 0, d);
    ps2d = 1'b1;
    repeat (TIMEOUT + 10) @(negedge clk);
    send_frame(8'h29, 0, 1, 0, 0, d);
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h0000_0129) begin n_fail++; $display("FAIL timeout_data: got %h want 00000129", d); end
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL timeout_empty: got %h want 0", d); end
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL timeout_flags: got %h want 0", d); end
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    ps2d = 1'b0;
    repeat (5) @(negedge clk);
    ps2c = 1'b0;
    repeat (2) @(negedge clk);
    ps2c = 1'b1;
    repeat (20) @(negedge clk);
    ps2d = 1'b1;
    send_frame(8'h6B, 0, 1, 1, 0, d);
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h0000_016B) begin n_fail++; $display("FAIL glitch_data: got %h want 0000016b", d); end
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_status: got %h want 0", d); end
  endtask

  task automatic test_aligned;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 0, 1, 0, 0, d);
    send_frame(8'h18, 0, 1, 0, 1, d);
    n_cmp++;
    if (d !== 32'h0000_0110) begin n_fail++; $display("FAIL aligned_pop: got %h want 00000110", d); end
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 32'h0000_0803) begin n_fail++; $display("FAIL aligned_status: got %h want 00000803", d); end
    for (int i = 1; i <= 8; i++) begin
      bus_read(2'd0, d);
      n_cmp++;
      if (d !== 32'h110 + 32'(i)) begin n_fail++; $display("FAIL aligned_data%0d: got %h want %h", i, d, 32'h110 + 32'(i)); end
    end
  endtask

  task automatic test_reserved;
    logic [31:0] d;
    send_frame(8'h33, 0, 1, 0, 0, d);
    bus_read(2'd2, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reserved2: got %h want 0", d); end
    bus_read(2'd3, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reserved3: got %h want 0", d); end
    bus_read(2'd1, d);
    n_cmp++;
    if (d !== 32'h0000_0101) begin n_fail++; $display("FAIL reserved_status: got %h want 00000101", d); end
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h0000_0133) begin n_fail++; $display("FAIL reserved_data: got %h want 00000133", d); end
  endtask

  task automatic test_mid_reset;
    logic [31:0] d;
    send_frame(8'h44, 0, 1, 0, 0, d);
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1, 0, 0, d);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 2'd1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rd_data !== 32'h0) begin n_fail++; $display("FAIL midrst_status: got %h want 0", rd_data); end
    n_cmp++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b want 0", irq); end
    rd_en = 1'b0; rd_addr = 2'd0; ps2d = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(2'd0, d);
    n_cmp++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_data: got %h want 0", d); end
  endtask

  task automatic test_random;
    logic [31:0] d, e;
    logic [7:0] b;
    logic [1:0] a;
    bit pb, sb;
    int unsigned nr;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); m_ovf = 0; m_ferr = 0; m_perr = 0;
    repeat (3) @(negedge clk);
    for (int it = 0; it < 15; it++) begin
      b  = 8'($urandom);
      pb = ($urandom_range(4) == 0);
      sb = ($urandom_range(5) != 0);
      send_frame(b, pb, sb, 0, 0, d);
      model_frame(b, pb, sb);
      n_cmp++;
      if (irq !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_irq%0d: got %b want %b", it, irq, mq.size() != 0); end
      nr = $urandom_range(2);
      for (int r = 0; r < int'(nr); r++) begin
        a = 2'($urandom_range(3));
        bus_read(a, d);
        model_read(a, e);
        n_cmp++;
        if (d !== e) begin n_fail++; $display("FAIL rnd_read%0d_a%0d: got %h want %h", it, a, d, e); end
      end
    end
    bus_read(2'd1, d);
    model_read(2'd1, e);
    n_cmp++;
    if (d !== e) begin n_fail++; $display("FAIL rnd_status: got %h want %h", d, e); end
    for (int r = 0; r <= int'(DEPTH); r++) begin
      bus_read(2'd0, d);
      model_read(2'd0, e);
      n_cmp++;
      if (d !== e) begin n_fail++; $display("FAIL rnd_drain%0d: got %h want %h", r, d, e); end
    end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_parity;
    test_stop_err;
    test_overflow;
    test_timeout;
    test_glitch;
    test_aligned;
    test_reserved;
    test_mid_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
